// File: rtl/stream_sink_checker.sv
// Stream sink that accepts 32-bit words under programmable back-pressure and checks them against base + i*step.
// Optional idle watchdog is compiled in with `define STREAM_SINK_TIMEOUT_EN.
module stream_sink_checker #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int STALL_W = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic [DATA_W-1:0] io_cfg_base,
    input  logic [DATA_W-1:0] io_cfg_step,
    input  logic [CNT_W-1:0]  io_cfg_count,
    input  logic [STALL_W-1:0] io_cfg_stall,
    input  logic [DATA_W-1:0] io_din,
    input  logic              io_din_v,
    output logic              io_din_r,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_err,
`ifdef STREAM_SINK_TIMEOUT_EN
    output logic              io_timeout,
`endif
    output logic [CNT_W-1:0]  io_rx_count,
    output logic [CNT_W-1:0]  io_err_count,
    output logic [CNT_W-1:0]  io_first_err_idx,
    output logic [DATA_W-1:0] io_first_err_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   expected;
    logic [DATA_W-1:0]   step_q;
    logic [CNT_W-1:0]    count_q;
    logic [STALL_W-1:0]  stall_q;
    logic [STALL_W-1:0]  stall_cnt;

    // Handshake: a word moves only on a rising edge with io_din_v and io_din_r both high;
    // io_din_r is a register driven from state and stall counter, never from io_din_v.
    logic              accept;
    logic              mismatch;
    logic [CNT_W-1:0]  rx_next;

    assign accept   = io_din_v && io_din_r;
    assign mismatch = (io_din != expected);
    assign rx_next  = io_rx_count + 1'b1;

`ifdef STREAM_SINK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_hit;
    assign timeout_hit = !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            expected          <= '0;
            step_q            <= '0;
            count_q           <= '0;
            stall_q           <= '0;
            stall_cnt         <= '0;
            io_din_r          <= 1'b0;
            io_busy           <= 1'b0;
            io_done           <= 1'b0;
            io_err            <= 1'b0;
            io_rx_count       <= '0;
            io_err_count      <= '0;
            io_first_err_idx  <= '0;
            io_first_err_data <= '0;
`ifdef STREAM_SINK_TIMEOUT_EN
            io_timeout        <= 1'b0;
            idle_cnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (io_start) begin
                        expected          <= io_cfg_base;
                        step_q            <= io_cfg_step;
                        count_q           <= io_cfg_count;
                        stall_q           <= io_cfg_stall;
                        stall_cnt         <= '0;
                        io_err            <= 1'b0;
                        io_rx_count       <= '0;
                        io_err_count      <= '0;
                        io_first_err_idx  <= '0;
                        io_first_err_data <= '0;
`ifdef STREAM_SINK_TIMEOUT_EN
                        io_timeout        <= 1'b0;
                        idle_cnt          <= '0;
`endif
                        // An empty run completes immediately without ever offering ready.
                        if (io_cfg_count == '0) begin
                            state    <= DONE;
                            io_busy  <= 1'b0;
                            io_done  <= 1'b1;
                            io_din_r <= 1'b0;
                        end else begin
                            state    <= RUN;
                            io_busy  <= 1'b1;
                            io_done  <= 1'b0;
                            io_din_r <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (accept) begin
                        expected    <= expected + step_q;
                        io_rx_count <= rx_next;
                        if (mismatch) begin
                            io_err <= 1'b1;
                            if (io_err_count != '1) begin
                                io_err_count <= io_err_count + 1'b1;
                            end
                            if (!io_err) begin
                                io_first_err_idx  <= io_rx_count;
                                io_first_err_data <= io_din;
                            end
                        end
`ifdef STREAM_SINK_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (rx_next == count_q) begin
                            state     <= DONE;
                            io_busy   <= 1'b0;
                            io_done   <= 1'b1;
                            io_din_r  <= 1'b0;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_q;
                            io_din_r  <= (stall_q == '0);
                        end
                    end else begin
                        // Ready returns on the cycle the stall counter reaches zero.
                        if (stall_cnt != '0) begin
                            stall_cnt <= stall_cnt - 1'b1;
                            io_din_r  <= (stall_cnt == STALL_W'(1));
                        end
`ifdef STREAM_SINK_TIMEOUT_EN
                        if (timeout_hit) begin
                            state      <= DONE;
                            io_busy    <= 1'b0;
                            io_done    <= 1'b1;
                            io_din_r   <= 1'b0;
                            io_timeout <= 1'b1;
                            stall_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    state    <= IDLE;
                    io_busy  <= 1'b0;
                    io_done  <= 1'b0;
                    io_din_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker: streaming, back-pressure, mismatch, wrap, zero count, reset, watchdog.
// Build with +define+STREAM_SINK_TIMEOUT_EN to include the watchdog step.
module tb_stream_sink_checker;

    logic        clock;
    logic        reset;
    logic        io_start;
    logic [31:0] io_cfg_base;
    logic [31:0] io_cfg_step;
    logic [15:0] io_cfg_count;
    logic [3:0]  io_cfg_stall;
    logic [31:0] io_din;
    logic        io_din_v;
    logic        io_din_r;
    logic        io_busy;
    logic        io_done;
    logic        io_err;
    logic [15:0] io_rx_count;
    logic [15:0] io_err_count;
    logic [15:0] io_first_err_idx;
    logic [31:0] io_first_err_data;
`ifdef STREAM_SINK_TIMEOUT_EN
    logic        io_timeout;
`endif

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_q[$];
    int          acc_cyc[$];
    logic [31:0] mon_e;

    stream_sink_checker #(
        .DATA_W(32), .CNT_W(16), .STALL_W(4), .TIMEOUT(16)
    ) dut (
`ifdef STREAM_SINK_TIMEOUT_EN
        .io_timeout(io_timeout),
`endif
        .clock(clock),
        .reset(reset),
        .io_start(io_start),
        .io_cfg_base(io_cfg_base),
        .io_cfg_step(io_cfg_step),
        .io_cfg_count(io_cfg_count),
        .io_cfg_stall(io_cfg_stall),
        .io_din(io_din),
        .io_din_v(io_din_v),
        .io_din_r(io_din_r),
        .io_busy(io_busy),
        .io_done(io_done),
        .io_err(io_err),
        .io_rx_count(io_rx_count),
        .io_err_count(io_err_count),
        .io_first_err_idx(io_first_err_idx),
        .io_first_err_data(io_first_err_data)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted word must be the oldest word the driver presented.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && io_din_v && io_din_r) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_accept", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("accept_data", io_din, mon_e);
            end
        end
    end

    // Driver tasks; all run at #1 after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [31:0] step,
                            input logic [15:0] count, input logic [3:0] stall);
        io_cfg_base  = base;
        io_cfg_step  = step;
        io_cfg_count = count;
        io_cfg_stall = stall;
        io_start     = 1'b1;
        tick();
        io_start     = 1'b0;
        io_cfg_base  = $urandom;
        io_cfg_step  = $urandom;
        io_cfg_count = 16'($urandom_range(1, 3));
        io_cfg_stall = 4'($urandom_range(0, 15));
        acc_cyc.delete();
    endtask

    task automatic send_word(input logic [31:0] w);
        int k;
        io_din   = w;
        io_din_v = 1'b1;
        exp_q.push_back(w);
        k = 0;
        while (!io_din_r && k < 50) begin
            tick();
            k++;
        end
        chk("accept_wait", 32'(k < 50), 32'd1);
        tick();
    endtask

    task automatic go_idle();
        io_din_v = 1'b0;
        io_din   = $urandom;
    endtask

    initial begin
        logic saw_r;
        reset        = 1'b1;
        io_start     = 1'b0;
        io_cfg_base  = '0;
        io_cfg_step  = '0;
        io_cfg_count = '0;
        io_cfg_stall = '0;
        io_din       = '0;
        io_din_v     = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_din_r", 32'(io_din_r), 32'd0);
        chk("rst_busy", 32'(io_busy), 32'd0);
        chk("rst_done", 32'(io_done), 32'd0);
        chk("rst_err", 32'(io_err), 32'd0);
        chk("rst_rx", 32'(io_rx_count), 32'd0);
        chk("rst_errcnt", 32'(io_err_count), 32'd0);
`ifdef STREAM_SINK_TIMEOUT_EN
        chk("rst_timeout", 32'(io_timeout), 32'd0);
`endif
        tick();

        // Streaming, no stall
        do_start(32'd1, 32'd2, 16'd5, 4'd0);
        chk("stream_busy", 32'(io_busy), 32'd1);
        chk("stream_ready", 32'(io_din_r), 32'd1);
        send_word(32'd1); send_word(32'd3); send_word(32'd5); send_word(32'd7); send_word(32'd9);
        go_idle();
        chk("stream_n_acc", 32'(acc_cyc.size()), 32'd5);
        if (acc_cyc.size() == 5) chk("stream_span", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
        chk("stream_rx", 32'(io_rx_count), 32'd5);
        chk("stream_err", 32'(io_err), 32'd0);
        chk("stream_done", 32'(io_done), 32'd1);
        chk("stream_busy_end", 32'(io_busy), 32'd0);
        chk("stream_ready_end", 32'(io_din_r), 32'd0);
        tick();

        // Back-pressure, stall=3
        do_start(32'd1, 32'd2, 16'd5, 4'd3);
        send_word(32'd1); send_word(32'd3); send_word(32'd5); send_word(32'd7); send_word(32'd9);
        go_idle();
        chk("bp_n_acc", 32'(acc_cyc.size()), 32'd5);
        if (acc_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) chk("bp_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
            chk("bp_span", 32'(acc_cyc[4] - acc_cyc[0] + 1), 32'd17);
        end
        chk("bp_rx", 32'(io_rx_count), 32'd5);
        chk("bp_err", 32'(io_err), 32'd0);
        chk("bp_done", 32'(io_done), 32'd1);
        tick();

        // Mismatch, with an io_start pulse mid-run that must be ignored
        do_start(32'd1, 32'd2, 16'd5, 4'd0);
        send_word(32'd1); send_word(32'd3);
        go_idle();
        io_cfg_base  = 32'd100;
        io_cfg_count = 16'd1;
        io_start     = 1'b1;
        tick();
        io_start = 1'b0;
        chk("mm_rx_mid", 32'(io_rx_count), 32'd2);
        send_word(32'd4); send_word(32'd7); send_word(32'd8);
        go_idle();
        chk("mm_rx", 32'(io_rx_count), 32'd5);
        chk("mm_errcnt", 32'(io_err_count), 32'd2);
        chk("mm_err", 32'(io_err), 32'd1);
        chk("mm_first_idx", 32'(io_first_err_idx), 32'd2);
        chk("mm_first_data", io_first_err_data, 32'd4);
        chk("mm_done", 32'(io_done), 32'd1);
        tick();
        chk("mm_hold_errcnt", 32'(io_err_count), 32'd2);

        // Wrap-around expected sequence
        do_start(32'hFFFF_FFFE, 32'd1, 16'd3, 4'd0);
        chk("wrap_err_cleared", 32'(io_err), 32'd0);
        send_word(32'hFFFF_FFFE); send_word(32'hFFFF_FFFF); send_word(32'h0000_0000);
        go_idle();
        chk("wrap_rx", 32'(io_rx_count), 32'd3);
        chk("wrap_err", 32'(io_err), 32'd0);
        chk("wrap_errcnt", 32'(io_err_count), 32'd0);
        tick();

        // Zero count: straight to DONE, never ready
        do_start(32'd5, 32'd1, 16'd0, 4'd0);
        chk("zero_done", 32'(io_done), 32'd1);
        chk("zero_busy", 32'(io_busy), 32'd0);
        chk("zero_rx", 32'(io_rx_count), 32'd0);
        io_din_v = 1'b1;
        io_din   = 32'd5;
        saw_r    = io_din_r;
        repeat (5) begin
            tick();
            saw_r = saw_r | io_din_r;
        end
        go_idle();
        chk("zero_never_ready", 32'(saw_r), 32'd0);

        // Reset mid-run with an in-flight word
        do_start(32'd1, 32'd1, 16'd5, 4'd0);
        send_word(32'd1); send_word(32'd99);
        io_din   = 32'd3;
        io_din_v = 1'b1;
        reset    = 1'b1;
        tick();
        chk("mrst_din_r", 32'(io_din_r), 32'd0);
        chk("mrst_busy", 32'(io_busy), 32'd0);
        chk("mrst_done", 32'(io_done), 32'd0);
        chk("mrst_err", 32'(io_err), 32'd0);
        chk("mrst_rx", 32'(io_rx_count), 32'd0);
        chk("mrst_errcnt", 32'(io_err_count), 32'd0);
        chk("mrst_first_idx", 32'(io_first_err_idx), 32'd0);
        chk("mrst_first_data", io_first_err_data, 32'd0);
        chk("mrst_n_acc", 32'(acc_cyc.size()), 32'd2);
        reset = 1'b0;
        go_idle();
        tick();
        do_start(32'd1, 32'd1, 16'd5, 4'd0);
        send_word(32'd1); send_word(32'd2); send_word(32'd3); send_word(32'd4); send_word(32'd5);
        go_idle();
        chk("restart_rx", 32'(io_rx_count), 32'd5);
        chk("restart_err", 32'(io_err), 32'd0);
        chk("restart_done", 32'(io_done), 32'd1);
        tick();

`ifdef STREAM_SINK_TIMEOUT_EN
        // Watchdog: two words then silence for TIMEOUT=16 cycles
        do_start(32'd10, 32'd1, 16'd4, 4'd0);
        send_word(32'd10); send_word(32'd11);
        go_idle();
        repeat (15) tick();
        chk("wd_not_yet", 32'(io_timeout), 32'd0);
        chk("wd_busy_yet", 32'(io_busy), 32'd1);
        tick();
        chk("wd_timeout", 32'(io_timeout), 32'd1);
        chk("wd_done", 32'(io_done), 32'd1);
        chk("wd_rx", 32'(io_rx_count), 32'd2);
        tick();
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
